// File: rtl/mem_master.sv
// mem_master: stalls the pipeline while a single load/store is carried out over a
// req/ack memory handshake, with address range checking and an ack timeout.
module mem_master #(
   parameter int BASE_ADDR = 1024,
   parameter int DEPTH     = 64,
   parameter int TIMEOUT   = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     MEM_R_EN,
   input  logic                     MEM_W_EN,
   input  logic [31:0]              alu_res,
   input  logic [31:0]              rm_val,
   output logic [31:0]              data_mem,
   output logic                     freeze,
   output logic                     mem_err,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [$clog2(DEPTH)-1:0] mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_ack
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, next_state;
   logic [CW-1:0] cnt;
   logic [32:0] byte_addr, offset;
   logic access, in_range, timed_out, latch, err_nxt;
   logic [31:0] data_nxt;
   // 33-bit arithmetic keeps the upper bound check safe from wraparound
   assign byte_addr = {1'b0, alu_res[31:2], 2'b00};
   assign offset    = byte_addr - 33'(BASE_ADDR);
   assign in_range  = (byte_addr >= 33'(BASE_ADDR)) && (offset < 33'(4 * DEPTH));
   assign access    = MEM_R_EN | MEM_W_EN;
   assign timed_out = cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= next_state;
   always_comb begin
      next_state = state == IDLE ? (access ? (in_range ? BUSY : DONE) : IDLE) :
                   state == BUSY ? ((mem_ack || timed_out) ? DONE : BUSY) : IDLE;
   end
   always_comb begin
      freeze   = (state == IDLE && access) || state == BUSY;
      latch    = state == IDLE && access && in_range;
      err_nxt  = (state == IDLE && access && !in_range) || (state == BUSY && !mem_ack && timed_out);
      data_nxt = next_state != DONE ? data_mem :
                 (state == BUSY && mem_ack && !mem_we) ? mem_rdata : 32'd0;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         data_mem  <= '0;
         mem_err   <= 1'b0;
         cnt       <= '0;
      end else begin
         mem_req  <= next_state == BUSY;
         mem_err  <= err_nxt;
         data_mem <= data_nxt;
         cnt      <= latch ? '0 : state == BUSY ? cnt + 1'b1 : cnt;
         if (latch) begin
            mem_addr  <= offset[AW+1:2];
            mem_wdata <= rm_val;
            mem_we    <= MEM_W_EN;
         end
      end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter BASE_ADDR, default 1024, SHALL be the byte address of data word 0.
REQ-002 Parameter DEPTH, default 64, SHALL be the number of 32-bit words addressable.
REQ-003 Parameter TIMEOUT, default 15, SHALL be the max BUSY cycles waited for mem_ack.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 MEM_R_EN  in  1  SHALL be the pipeline load request.
REQ-007 MEM_W_EN  in  1  SHALL be the pipeline store request.
REQ-008 alu_res  in  32  SHALL be the byte address.
REQ-009 rm_val  in  32  SHALL be the store data.
REQ-010 data_mem  out  32  SHALL be the load result returned to the pipeline.
REQ-011 freeze  out  1  SHALL be the pipeline stall.
REQ-012 mem_err  out  1  SHALL be a one-cycle error pulse.
REQ-013 mem_req  out  1  SHALL be the request to the memory responder.
REQ-014 mem_we  out  1  SHALL be the write qualifier, 1=write.
REQ-015 mem_addr  out  $clog2(DEPTH)  SHALL be the word index.
REQ-016 mem_wdata  out  32  SHALL be the write data.
REQ-017 mem_rdata  in  32  SHALL be the read data, valid with mem_ack.
REQ-018 mem_ack  in  1  SHALL be the responder completion strobe.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-020 In IDLE, an access with an in-range address SHALL latch mem_addr=(alu_res-BASE_ADDR)>>2, mem_wdata=rm_val and mem_we=MEM_W_EN, then go to BUSY.
REQ-021 In-range SHALL mean BASE_ADDR <= alu_res < BASE_ADDR+4*DEPTH (unsigned); alu_res[1:0] SHALL be ignored.
REQ-022 If MEM_R_EN and MEM_W_EN are both 1, the access SHALL be a write.
REQ-023 An access with an out-of-range address SHALL issue no request, pulse mem_err for 1 cycle in DONE, return data_mem=0, and go IDLE->DONE.
REQ-024 mem_req SHALL be registered, 1 exactly while in BUSY; mem_addr, mem_we and mem_wdata SHALL hold stable while mem_req=1.
REQ-025 In BUSY, mem_ack=1 at a posedge SHALL go to DONE; on a read, data_mem SHALL be loaded from mem_rdata at that edge.
REQ-026 On a write completion, data_mem SHALL be 0.
REQ-027 A BUSY cycle counter SHALL clear on BUSY entry.
REQ-028 If TIMEOUT BUSY cycles elapse without mem_ack, the FSM SHALL go to DONE with data_mem=0 and a mem_err pulse in DONE.
REQ-029 freeze SHALL be combinational: 1 in IDLE while (MEM_R_EN|MEM_W_EN), 1 in BUSY, 0 in DONE.
REQ-030 DONE SHALL last 1 cycle, ignore enables and mem_ack, then return to IDLE; the pipeline advances at the end of DONE.
REQ-031 data_mem SHALL hold its value until the next completion.
REQ-032 mem_ack outside BUSY SHALL be ignored.
REQ-033 Minimum latency (ack in first BUSY cycle) SHALL be freeze high for 2 cycles and data valid in cycle 3.

Reset
REQ-034 On rst=0: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_mem=0, mem_err=0, counter=0; freeze follows REQ-029.
REQ-035 Reset asserted in BUSY SHALL drop mem_req immediately (asynchronously) and discard the pending access.

Verification
REQ-036 Store alu_res=1028, rm_val=0xDEADBEEF, ack on the 1st BUSY cycle -> mem_req 1 cycle, mem_we=1, mem_addr=1, mem_wdata=0xDEADBEEF, freeze 2 cycles, mem_err=0.
REQ-037 Load alu_res=1032, ack after 3 BUSY cycles with mem_rdata=0x12345678 -> mem_addr=2, freeze 4 cycles, data_mem=0x12345678 in DONE and held afterwards.
REQ-038 Load alu_res=1020, then alu_res=1280 -> no mem_req, 1-cycle mem_err each, data_mem=0, freeze 1 cycle each.
REQ-039 Load alu_res=1024 with no ack -> mem_req held 15 cycles, then DONE with mem_err=1 and data_mem=0.
REQ-040 Both enables set, alu_res=1276 -> mem_we=1, mem_addr=63.
REQ-041 Reset pulsed mid-BUSY, then ack -> mem_req=0 immediately, ack ignored, all outputs at reset values.
